// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: NOP encoding, fetch FSM states and
// instruction field positions used by the fetch unit and the IF/ID register.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      S_ISSUE = 1'b0,
      S_WAIT  = 1'b1
   } fetch_state_e;

   localparam int OP_LSB       = 0;
   localparam int OP_MSB       = 6;
   localparam int OPB5_BIT     = 5;
   localparam int FUNCT3_LSB   = 12;
   localparam int FUNCT3_MSB   = 14;
   localparam int FUNCT7B5_BIT = 30;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, hold, flush-to-NOP, plus the decoded fields
// that feed the control unit directly.
module if_id_reg
   import riscv_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            load_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] instr_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            valid_o,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pcplus4_o,
   output logic [6:0]      op_o,
   output logic [2:0]      funct3_o,
   output logic            funct7b5_o,
   output logic            opb5_o
);

   logic            valid_q,   valid_d;
   logic [XLEN-1:0] instr_q,   instr_d;
   logic [XLEN-1:0] pc_q,      pc_d;
   logic [XLEN-1:0] pcplus4_q, pcplus4_d;

   // Flush wins over load; a flushed slot keeps its PC so pc/pcplus4 never glitch.
   always_comb begin
      valid_d   = valid_q;
      instr_d   = instr_q;
      pc_d      = pc_q;
      pcplus4_d = pcplus4_q;
      if (flush_i) begin
         valid_d = 1'b0;
         instr_d = XLEN'(NOP_INSTR);
      end else if (load_i) begin
         valid_d   = 1'b1;
         instr_d   = instr_i;
         pc_d      = pc_i;
         pcplus4_d = pc_i + XLEN'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= 1'b0;
         instr_q   <= XLEN'(NOP_INSTR);
         pc_q      <= RESET_PC;
         pcplus4_q <= RESET_PC + XLEN'(4);
      end else begin
         valid_q   <= valid_d;
         instr_q   <= instr_d;
         pc_q      <= pc_d;
         pcplus4_q <= pcplus4_d;
      end
   end

   assign valid_o    = valid_q;
   assign instr_o    = instr_q;
   assign pc_o       = pc_q;
   assign pcplus4_o  = pcplus4_q;
   assign op_o       = instr_q[OP_MSB:OP_LSB];
   assign funct3_o   = instr_q[FUNCT3_MSB:FUNCT3_LSB];
   assign funct7b5_o = instr_q[FUNCT7B5_BIT];
   assign opb5_o     = instr_q[OPB5_BIT];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues single-outstanding requests to
// instruction memory, absorbs decode stalls in a one-entry skid, handles redirects.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0
)(
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_valid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            pc_src,
   input  logic [XLEN-1:0] pc_target,
   input  logic            stall_d,
   output logic            valid_d,
   output logic [XLEN-1:0] instr_d,
   output logic [XLEN-1:0] pc_d,
   output logic [XLEN-1:0] pcplus4_d,
   output logic [6:0]      op_d,
   output logic [2:0]      funct3_d,
   output logic            funct7b5_d,
   output logic            opb5_d
);

   fetch_state_e    state_q,      state_d;
   logic [XLEN-1:0] fetch_pc_q,   fetch_pc_d;
   logic            drop_q,       drop_d;
   logic            skid_valid_q, skid_valid_d;
   logic [XLEN-1:0] skid_instr_q, skid_instr_d;
   logic [XLEN-1:0] skid_pc_q,    skid_pc_d;

   logic            decode_accept;
   logic            issue;
   logic [XLEN-1:0] fetch_pc_inc;
   logic [XLEN-1:0] target_aligned;
   logic            ifid_load;
   logic            ifid_flush;
   logic [XLEN-1:0] ifid_instr;
   logic [XLEN-1:0] ifid_pc;

   assign decode_accept  = !valid_d || !stall_d;
   assign fetch_pc_inc   = fetch_pc_q + XLEN'(4);
   assign target_aligned = pc_target & ~XLEN'(3);

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      drop_d       = drop_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      issue        = 1'b0;
      imem_addr    = fetch_pc_q;
      ifid_load    = 1'b0;
      ifid_instr   = skid_instr_q;
      ifid_pc      = skid_pc_q;

      unique case (state_q)
         S_ISSUE: begin
            // The skid must drain before anything new is requested.
            issue = !skid_valid_q && !reset;
            if (pc_src) begin
               fetch_pc_d   = target_aligned;
               skid_valid_d = 1'b0;
               // An old-PC request slipping through this cycle is discarded on return.
               if (issue && imem_ready) begin
                  state_d = S_WAIT;
                  drop_d  = 1'b1;
               end
            end else begin
               if (issue && imem_ready) begin
                  state_d = S_WAIT;
               end
               if (skid_valid_q && decode_accept) begin
                  ifid_load    = 1'b1;
                  skid_valid_d = 1'b0;
               end
            end
         end

         S_WAIT: begin
            if (pc_src) begin
               fetch_pc_d   = target_aligned;
               skid_valid_d = 1'b0;
               if (imem_valid) begin
                  drop_d  = 1'b0;
                  state_d = S_ISSUE;
               end else begin
                  drop_d  = 1'b1;
               end
            end else if (imem_valid && drop_q) begin
               drop_d  = 1'b0;
               state_d = S_ISSUE;
            end else if (imem_valid) begin
               fetch_pc_d = fetch_pc_inc;
               if (decode_accept) begin
                  ifid_load  = 1'b1;
                  ifid_instr = imem_rdata;
                  ifid_pc    = fetch_pc_q;
                  // Overlap the next request with this response for full throughput.
                  issue      = !reset;
                  imem_addr  = fetch_pc_inc;
                  state_d    = (issue && imem_ready) ? S_WAIT : S_ISSUE;
               end else begin
                  skid_valid_d = 1'b1;
                  skid_instr_d = imem_rdata;
                  skid_pc_d    = fetch_pc_q;
                  state_d      = S_ISSUE;
               end
            end
         end

         default: begin
            state_d = S_ISSUE;
         end
      endcase

      ifid_flush = pc_src || (decode_accept && !ifid_load);
   end

   assign imem_req = issue;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_ISSUE;
         fetch_pc_q   <= RESET_PC;
         drop_q       <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= XLEN'(NOP_INSTR);
         skid_pc_q    <= RESET_PC;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         drop_q       <= drop_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

   if_id_reg #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_if_id_reg (
      .clk        (clk),
      .reset      (reset),
      .load_i     (ifid_load),
      .flush_i    (ifid_flush),
      .instr_i    (ifid_instr),
      .pc_i       (ifid_pc),
      .valid_o    (valid_d),
      .instr_o    (instr_d),
      .pc_o       (pc_d),
      .pcplus4_o  (pcplus4_d),
      .op_o       (op_d),
      .funct3_o   (funct3_d),
      .funct7b5_o (funct7b5_d),
      .opb5_o     (opb5_d)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small latency-configurable memory model.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic        pc_src = 1'b0;
   logic [31:0] pc_target = '0;
   logic        stall_d = 1'b0;
   logic        valid_d;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pcplus4_d;
   logic [6:0]  op_d;
   logic [2:0]  funct3_d;
   logic        funct7b5_d;
   logic        opb5_d;

   int checks = 0;
   int errors = 0;

   // memory model: ready after rdy_wait cycles of pending request, response lat cycles after accept
   int          rdy_wait = 0;
   int          lat = 1;
   int          wait_cnt = 0;
   int          cnt = 0;
   logic [31:0] pend_addr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0)      return 32'h0050_0093;
      else if (a == 32'h4) return 32'h00A0_0113;
      else                 return {a[19:0], 12'h013};
   endfunction

   assign imem_ready = (wait_cnt >= rdy_wait);
   assign imem_valid = (cnt == 1);
   assign imem_rdata = mem_word(pend_addr);

   always @(posedge clk) begin
      if (cnt > 0) cnt <= cnt - 1;
      if (imem_req && imem_ready) begin
         cnt       <= lat;
         pend_addr <= imem_addr;
         wait_cnt  <= 0;
      end else if (imem_req) begin
         wait_cnt  <= wait_cnt + 1;
      end
   end

   always #5 clk = ~clk;

   instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_valid (imem_valid),
      .imem_rdata (imem_rdata),
      .pc_src     (pc_src),
      .pc_target  (pc_target),
      .stall_d    (stall_d),
      .valid_d    (valid_d),
      .instr_d    (instr_d),
      .pc_d       (pc_d),
      .pcplus4_d  (pcplus4_d),
      .op_d       (op_d),
      .funct3_d   (funct3_d),
      .funct7b5_d (funct7b5_d),
      .opb5_d     (opb5_d)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
      check({tag, "_req"}, 32'(imem_req), 32'(req));
      if (req) check({tag, "_addr"}, imem_addr, addr);
   endtask

   task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins,
                           input logic [31:0] pc);
      check({tag, "_valid"}, 32'(valid_d), 32'(v));
      check({tag, "_instr"}, instr_d, ins);
      check({tag, "_pc"}, pc_d, pc);
      check({tag, "_pc4"}, pcplus4_d, pc + 32'd4);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      repeat (3) tick();
      #1;
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      chk_ifid("rst", 1'b0, 32'h13, 32'h0);
      $display("step reset: values checked");

      // C0..C3: first fetches with zero-wait memory
      reset = 1'b0; #1;
      chk_req("c0", 1'b1, 32'h0);
      tick(); #1;
      chk_req("c1", 1'b1, 32'h4);
      check("c1_valid", 32'(valid_d), 32'd0);
      tick(); #1;
      chk_ifid("c2", 1'b1, 32'h0050_0093, 32'h0);
      check("c2_op", 32'(op_d), 32'h13);
      check("c2_funct3", 32'(funct3_d), 32'd0);
      check("c2_f7b5", 32'(funct7b5_d), 32'd0);
      check("c2_opb5", 32'(opb5_d), 32'd0);
      chk_req("c2", 1'b1, 32'h8);
      $display("step first fetch: instr %h pc %h", instr_d, pc_d);

      // C3..C9: stall three cycles with a response in flight
      tick(); stall_d = 1'b1; #1;
      chk_ifid("c3", 1'b1, 32'h00A0_0113, 32'h4);
      chk_req("c3", 1'b0, 32'h0);
      tick(); #1;
      chk_ifid("c4", 1'b1, 32'h00A0_0113, 32'h4);
      chk_req("c4", 1'b0, 32'h0);
      tick(); #1;
      chk_req("c5", 1'b0, 32'h0);
      tick(); stall_d = 1'b0; #1;
      chk_req("c6", 1'b0, 32'h0);
      check("c6_instr", instr_d, 32'h00A0_0113);
      tick(); #1;
      chk_ifid("c7", 1'b1, 32'h0000_8013, 32'h8);
      chk_req("c7", 1'b1, 32'hC);
      tick(); #1;
      check("c8_valid", 32'(valid_d), 32'd0);
      check("c8_instr", instr_d, 32'h13);
      check("c8_pc", pc_d, 32'h8);
      chk_req("c8", 1'b1, 32'h10);
      tick(); lat = 3; #1;
      chk_ifid("c9", 1'b1, 32'h0000_C013, 32'hC);
      chk_req("c9", 1'b1, 32'h14);
      $display("step stall/skid: instr %h pc %h", instr_d, pc_d);

      // C10..C15: redirect while a request is outstanding
      tick(); pc_src = 1'b1; pc_target = 32'h100; lat = 1; #1;
      chk_ifid("c10", 1'b1, 32'h0001_0013, 32'h10);
      chk_req("c10", 1'b0, 32'h0);
      tick(); pc_src = 1'b0; #1;
      check("c11_valid", 32'(valid_d), 32'd0);
      check("c11_instr", instr_d, 32'h13);
      chk_req("c11", 1'b0, 32'h0);
      tick(); #1;
      check("c12_respin", 32'(imem_valid), 32'd1);
      chk_req("c12", 1'b0, 32'h0);
      check("c12_valid", 32'(valid_d), 32'd0);
      tick(); #1;
      chk_req("c13", 1'b1, 32'h100);
      check("c13_valid", 32'(valid_d), 32'd0);
      tick(); #1;
      chk_req("c14", 1'b1, 32'h104);
      check("c14_valid", 32'(valid_d), 32'd0);
      $display("step redirect wait: addr %h", imem_addr);

      // C15..C20: redirect with response, then redirect with issue handshake
      tick(); pc_src = 1'b1; pc_target = 32'h200; #1;
      chk_ifid("c15", 1'b1, 32'h0010_0013, 32'h100);
      chk_req("c15", 1'b0, 32'h0);
      tick(); pc_target = 32'h300; #1;
      check("c16_valid", 32'(valid_d), 32'd0);
      chk_req("c16", 1'b1, 32'h200);
      tick(); pc_src = 1'b0; #1;
      check("c17_valid", 32'(valid_d), 32'd0);
      chk_req("c17", 1'b0, 32'h0);
      tick(); #1;
      chk_req("c18", 1'b1, 32'h300);
      check("c18_valid", 32'(valid_d), 32'd0);
      tick(); #1;
      check("c19_valid", 32'(valid_d), 32'd0);
      chk_req("c19", 1'b1, 32'h304);
      $display("step redirect handshake: addr %h", imem_addr);

      // C20..C26: slow memory, ready low 2 cycles, latency 3
      tick(); rdy_wait = 2; lat = 3; #1;
      chk_ifid("c20", 1'b1, 32'h0030_0013, 32'h300);
      chk_req("c20", 1'b1, 32'h308);
      tick(); #1;
      chk_ifid("c21", 1'b1, 32'h0030_4013, 32'h304);
      chk_req("c21", 1'b1, 32'h308);
      tick(); #1;
      chk_req("c22", 1'b1, 32'h308);
      check("c22_valid", 32'(valid_d), 32'd0);
      tick(); #1;
      chk_req("c23", 1'b0, 32'h0);
      tick(); #1;
      check("c24_valid", 32'(valid_d), 32'd0);
      tick(); #1;
      check("c25_valid", 32'(valid_d), 32'd0);
      chk_req("c25", 1'b1, 32'h30C);
      tick(); rdy_wait = 0; lat = 1; #1;
      chk_ifid("c26", 1'b1, 32'h0030_8013, 32'h308);
      $display("step slow memory: instr %h pc %h", instr_d, pc_d);

      // C27..C34: misaligned target, then wrap at top of address space
      tick(); pc_src = 1'b1; pc_target = 32'h103; #1;
      tick(); pc_src = 1'b0; #1;
      chk_req("c28", 1'b1, 32'h100);
      check("c28_valid", 32'(valid_d), 32'd0);
      tick(); #1;
      chk_req("c29", 1'b1, 32'h104);
      tick(); pc_src = 1'b1; pc_target = 32'hFFFF_FFFC; #1;
      chk_ifid("c30", 1'b1, 32'h0010_0013, 32'h100);
      tick(); pc_src = 1'b0; #1;
      chk_req("c31", 1'b1, 32'hFFFF_FFFC);
      tick(); #1;
      chk_req("c32", 1'b1, 32'h0);
      tick(); #1;
      chk_ifid("c33", 1'b1, 32'hFFFF_C013, 32'hFFFF_FFFC);
      tick(); #1;
      chk_ifid("c34", 1'b1, 32'h0050_0093, 32'h0);
      $display("step misaligned/wrap: instr %h pc %h", instr_d, pc_d);

      // C35..C36: reset in the middle of traffic
      tick(); reset = 1'b1; #1;
      chk_req("c35", 1'b0, 32'h0);
      tick(); reset = 1'b0; #1;
      chk_ifid("c36", 1'b0, 32'h13, 32'h0);
      chk_req("c36", 1'b1, 32'h0);
      tick(); #1;
      chk_req("c37", 1'b1, 32'h4);
      tick(); #1;
      chk_ifid("c38", 1'b1, 32'h0050_0093, 32'h0);
      $display("step mid reset: instr %h pc %h", instr_d, pc_d);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
